count_reporter: RTL and testbench

// - Downstream consumer of the dual 64-bit event counter (Output0/Output1).
// - On Req, snapshots both counts atomically and streams them out as a framed

---
 rtl/count_report_pkg.sv | 35 +++
 rtl/report_shifter.sv | 48 ++++
 rtl/count_reporter.sv | 165 ++++++++++++++++
 tb/tb_count_reporter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/count_report_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_report_pkg
//  Description : Shared definitions for the count reporter. Holds the frame
//                state encoding, the default frame header byte and the
//                bytes-per-count helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package count_report_pkg;

  // Frame state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_HDR     = ST_HDR,
    S_PAYLOAD = ST_PAYLOAD,
    S_CSUM    = ST_CSUM
  } state_t;

  localparam logic [7:0]  HDR_DEFAULT   = 8'hA5;
  localparam int unsigned CNT_W_DEFAULT = 64;
  localparam int unsigned BYTES_PER_CNT = CNT_W_DEFAULT / 8;

  // Bytes carried by one count of the given bit width
  function automatic int unsigned bytes_per_cnt(input int unsigned width);
    return width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/report_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : report_shifter
//  Description : Shadow register for the two captured counts. It loads
//                {cnt0,cnt1} on a snapshot and shifts left one byte per
//                payload transfer, so the byte to send is always at the top.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                load              - capture {cnt0,cnt1}
//                shift             - shift left by 8 bits
//                cnt0, cnt1        - live counts
//                top_byte          - byte currently at the top of the shadow
//                next_byte         - byte that becomes the top after a shift
//  Revision    : 1.0 - initial release
// ============================================================================
module report_shifter
  import count_report_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  output logic [7:0]       top_byte,
  output logic [7:0]       next_byte
);

  localparam int unsigned SH_W = 2 * CNT_W;

  logic [SH_W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= {cnt0, cnt1};
    end else if (shift) begin
      shadow <= {shadow[SH_W-9:0], 8'h00};
    end
  end

  assign top_byte  = shadow[SH_W-1 -: 8];
  assign next_byte = shadow[SH_W-9 -: 8];

endmodule
`default_nettype wire

// File: rtl/count_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : count_reporter
//  Description : Snapshots two event counts on Req and streams them as a
//                framed byte sequence over a valid/ready link:
//                HDR, Cnt0 (MSB first), Cnt1 (MSB first) [, checksum].
//                Counts keep running while a frame is in flight.
//  Build option: REPORT_CSUM_EN - when defined, a trailing byte holding the
//                XOR of all payload bytes is appended to each frame.
//  Ports       : Clk, Reset_n      - clock, async active-low reset
//                Req               - report request, sampled while idle
//                Cnt0, Cnt1        - counts to report
//                Tx_Data, Tx_Valid - byte stream out
//                Tx_Ready          - sink ready
//                Busy              - frame in flight
//                Done              - one-cycle pulse after the last byte
//  Revision    : 1.0 - initial release
// ============================================================================
module count_reporter
  import count_report_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter logic [7:0]  HDR   = HDR_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Req,
  input  logic [CNT_W-1:0] Cnt0,
  input  logic [CNT_W-1:0] Cnt1,
  output logic [7:0]       Tx_Data,
  output logic             Tx_Valid,
  input  logic             Tx_Ready,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned     PAYLOAD_BYTES = 2 * bytes_per_cnt(CNT_W);
  localparam int unsigned     IDX_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(PAYLOAD_BYTES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       data_nxt;
  logic             done_nxt;
  logic             load;
  logic             shift;
  logic             xfer;
  logic [7:0]       top_byte;
  logic [7:0]       next_byte;
`ifdef REPORT_CSUM_EN
  logic [7:0]       acc;
  logic [7:0]       acc_nxt;
`endif

  report_shifter #(
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .load      (load),
    .shift     (shift),
    .cnt0      (Cnt0),
    .cnt1      (Cnt1),
    .top_byte  (top_byte),
    .next_byte (next_byte)
  );

  // Valid is a pure function of state so an async reset retracts it at once.
  assign Tx_Valid = (state != S_IDLE);
  assign Busy     = (state != S_IDLE);
  assign xfer     = Tx_Valid && Tx_Ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      Tx_Data <= 8'h00;
      Done    <= 1'b0;
`ifdef REPORT_CSUM_EN
      acc     <= 8'h00;
`endif
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      Tx_Data <= data_nxt;
      Done    <= done_nxt;
`ifdef REPORT_CSUM_EN
      acc     <= acc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = Tx_Data;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
`ifdef REPORT_CSUM_EN
    acc_nxt   = acc;
`endif
    case (state)
      S_IDLE: begin
        data_nxt = 8'h00;
        if (Req) begin
          state_nxt = S_HDR;
          load      = 1'b1;
          data_nxt  = HDR;
          idx_nxt   = '0;
`ifdef REPORT_CSUM_EN
          acc_nxt   = 8'h00;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          // Shadow already holds the capture; its top byte is payload byte 0.
          state_nxt = S_PAYLOAD;
          data_nxt  = top_byte;
          idx_nxt   = '0;
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          shift   = 1'b1;
          idx_nxt = idx + 1'b1;
`ifdef REPORT_CSUM_EN
          acc_nxt = acc ^ top_byte;
`endif
          if (idx == LAST_IDX) begin
`ifdef REPORT_CSUM_EN
            state_nxt = S_CSUM;
            data_nxt  = acc ^ top_byte;
`else
            state_nxt = S_IDLE;
            data_nxt  = 8'h00;
            done_nxt  = 1'b1;
`endif
          end else begin
            // Byte under the top moves up on this shift.
            data_nxt = next_byte;
          end
        end
      end
`ifdef REPORT_CSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_nxt = S_IDLE;
          data_nxt  = 8'h00;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        data_nxt  = 8'h00;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_count_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_reporter
//  Description : Self-checking bench for count_reporter. Expected frames are
//                built from the captured counts as a byte queue and compared
//                against every handshaked byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_reporter;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [63:0] cnt0;
  logic [63:0] cnt1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  count_reporter #(
    .CNT_W (64),
    .HDR   (8'hA5)
  ) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Req      (req),
    .Cnt0     (cnt0),
    .Cnt1     (cnt1),
    .Tx_Data  (tx_data),
    .Tx_Valid (tx_valid),
    .Tx_Ready (tx_ready),
    .Busy     (busy),
    .Done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 ready always, 1 ready toggles 0/1, 2 ready always with Req held
  // and Cnt0 incrementing, 3 random ready and random Req during the frame.
  task automatic do_frame(input logic [63:0] c0, input logic [63:0] c1,
                          input int mode, input bit started, input int abort_at,
                          output logic [63:0] cap0, output logic [63:0] cap1);
    logic [7:0] exp_q[$];
    logic [7:0] cs;
    logic [7:0] prev_data;
    bit         prev_stall;
    bit         rdy;
    int         n;
    int         cyc;

    cap0 = c0;
    cap1 = c1;
    cs   = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(c0[i*8 +: 8]);
      cs = cs ^ c0[i*8 +: 8];
    end
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(c1[i*8 +: 8]);
      cs = cs ^ c1[i*8 +: 8];
    end
`ifdef REPORT_CSUM_EN
    exp_q.push_back(cs);
`endif

    if (!started) begin
      cnt0 = c0;
      cnt1 = c1;
      req  = 1'b1;
      @(negedge clk);
    end
    if (mode != 2) req = 1'b0;
    check("busy_start", busy, 1);
    check("hdr_first", tx_data, 8'hA5);

    n = 0;
    cyc = 0;
    prev_stall = 0;
    prev_data = 8'h00;
    while (n < exp_q.size() && cyc < 400) begin
      if (abort_at > 0 && n == abort_at) begin
        tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        check("abort_no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done2", done, 0);
        check("abort_idle", busy, 0);
        return;
      end
      check("valid", tx_valid, 1);
      check("no_early_done", done, 0);
      if (prev_stall) check("stall_hold", tx_data, prev_data);
      if (mode == 2) begin
        cnt0 = cnt0 + 64'd1;
      end else begin
        cnt0 = {$urandom, $urandom};
        cnt1 = {$urandom, $urandom};
      end
      if (mode == 3) req = $urandom_range(0, 1) == 1;
      case (mode)
        1:       rdy = (cyc % 2) == 1;
        3:       rdy = $urandom_range(0, 2) != 0;
        default: rdy = 1'b1;
      endcase
      tx_ready = rdy;
      if (rdy) begin
        check("byte", tx_data, exp_q[n]);
        n++;
        prev_stall = 0;
      end else begin
        prev_stall = 1;
        prev_data  = tx_data;
      end
      cyc++;
      @(negedge clk);
    end
    if (n < exp_q.size()) check("timeout", n, exp_q.size());

    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("valid_end", tx_valid, 0);
    if (mode == 0 || mode == 2) check("cycles_full", cyc, exp_q.size());
    if (mode == 1) check("cycles_toggle", cyc, 2 * exp_q.size());
    tx_ready = 1'b0;
    if (mode == 2) begin
      // Req still high in the Done cycle: a new frame captures these values.
      cnt0 = cnt0 + 64'd1;
      cap0 = cnt0;
      cap1 = cnt1;
      @(negedge clk);
      req = 1'b0;
      check("done_clears", done, 0);
    end else begin
      req = 1'b0;
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(negedge clk);
    check("gap_busy", busy, 0);
    check("gap_done", done, 0);
  endtask

  logic [63:0] k0;
  logic [63:0] k1;

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    cnt0     = '0;
    cnt1     = '0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", tx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    do_frame(64'h3, 64'h1, 0, 0, 0, k0, k1);
    idle_gap(2);
    do_frame(64'h3, 64'h1, 1, 0, 0, k0, k1);
    idle_gap(1);
    do_frame(64'h0123456789ABCDEF, ~64'h0123456789ABCDEF, 0, 0, 0, k0, k1);
    idle_gap(1);
    // Req held through the frame; the follow-on frame starts on the Done cycle.
    do_frame(64'h10, 64'h55AA, 2, 0, 0, k0, k1);
    do_frame(k0, k1, 0, 1, 0, k0, k1);
    idle_gap(1);
    // Abort after the fifth byte, then a complete fresh frame.
    do_frame(64'hDEADBEEFCAFEF00D, 64'h1122334455667788, 0, 0, 5, k0, k1);
    do_frame(64'hDEADBEEFCAFEF00D, 64'h1122334455667788, 0, 0, 0, k0, k1);

    for (int f = 0; f < 12; f++) begin
      idle_gap($urandom_range(1, 3));
      do_frame({$urandom, $urandom}, {$urandom, $urandom}, 3, 0, 0, k0, k1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
